// File: rtl/dcache_pkg.sv
// Shared types and width helpers for the direct-mapped write-through data cache.
package dcache_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REFILL,
        WRITE,
        DONE
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    function automatic int offset_w(input int words_per_line);
        return $clog2(words_per_line);
    endfunction

    function automatic int index_w(input int lines);
        return $clog2(lines);
    endfunction

    // Remaining address bits above the byte, word and index fields.
    function automatic int tag_w(input int lines, input int words_per_line);
        return 30 - $clog2(lines) - $clog2(words_per_line);
    endfunction

endpackage

// File: rtl/dcache_store_align.sv
// Store lane alignment: byte enables and lane-replicated data for SB/SH/SW.
module dcache_store_align
    import dcache_pkg::*;
(
    input  logic [2:0]  f3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata_rep
);

    always_comb begin
        wstrb     = 4'b1111;
        wdata_rep = wdata;
        case (f3)
            F3_B, F3_BU: begin
                wstrb     = 4'b0001 << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
            end
            F3_H, F3_HU: begin
                wstrb     = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{wdata[15:0]}};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller for the M stage.
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int LINES          = 16,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        core_req,
    input  logic        core_we,
    input  logic [2:0]  core_f3,
    input  logic [31:0] core_addr,
    input  logic [31:0] core_wdata,
    output logic [31:0] core_rdata,
    output logic        waiting,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);

    localparam int OFF_W  = offset_w(WORDS_PER_LINE);
    localparam int IDX_W  = index_w(LINES);
    localparam int TAG_W  = tag_w(LINES, WORDS_PER_LINE);
    localparam int TAG_LO = 2 + OFF_W + IDX_W;

    state_t             state;
    logic [31:2]        req_addr;
    logic [OFF_W-1:0]   beat;
    logic [OFF_W-1:0]   next_beat;
    logic [LINES-1:0]   valid;
    logic [TAG_W-1:0]   tags [LINES];
    logic [31:0]        data [LINES][WORDS_PER_LINE];

    logic [TAG_W-1:0]   c_tag, r_tag;
    logic [IDX_W-1:0]   c_idx, r_idx;
    logic [OFF_W-1:0]   c_off, r_off;
    logic               c_hit, r_hit;
    logic               start_fill, start_write, last_beat, fill_we, merge_we;
    logic [3:0]         st_strb;
    logic [31:0]        st_data;

    assign c_tag = core_addr[31 -: TAG_W];
    assign c_idx = core_addr[TAG_LO-1 -: IDX_W];
    assign c_off = core_addr[2 +: OFF_W];
    assign c_hit = valid[c_idx] && (tags[c_idx] == c_tag);

    assign r_tag = req_addr[31 -: TAG_W];
    assign r_idx = req_addr[TAG_LO-1 -: IDX_W];
    assign r_off = req_addr[2 +: OFF_W];
    assign r_hit = valid[r_idx] && (tags[r_idx] == r_tag);

    assign start_fill  = (state == IDLE) && core_req && !core_we && !c_hit;
    assign start_write = (state == IDLE) && core_req && core_we;
    assign waiting     = start_fill || start_write || (state == REFILL) || (state == WRITE);
    assign next_beat   = beat + 1'b1;
    assign last_beat   = &beat;
    assign fill_we     = (state == REFILL) && mem_ready;
    assign merge_we    = (state == WRITE) && mem_ready && r_hit;

    assign core_rdata  = (core_req && !waiting && c_hit) ? data[c_idx][c_off] : 32'h0;

    dcache_store_align u_align (
        .f3        (core_f3),
        .addr_lo   (core_addr[1:0]),
        .wdata     (core_wdata),
        .wstrb     (st_strb),
        .wdata_rep (st_data)
    );

    // The line's valid bit drops when its refill starts, so an interrupted refill never hits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            valid     <= '0;
            beat      <= '0;
            req_addr  <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_fill) begin
                        req_addr     <= core_addr[31:2];
                        beat         <= '0;
                        valid[c_idx] <= 1'b0;
                        mem_req      <= 1'b1;
                        mem_we       <= 1'b0;
                        mem_addr     <= {core_addr[31:2+OFF_W], {OFF_W{1'b0}}, 2'b00};
                        state        <= REFILL;
                    end else if (start_write) begin
                        req_addr  <= core_addr[31:2];
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= {core_addr[31:2], 2'b00};
                        mem_wdata <= st_data;
                        mem_wstrb <= st_strb;
                        state     <= WRITE;
                    end
                end
                REFILL: begin
                    if (mem_ready) begin
                        beat     <= next_beat;
                        mem_addr <= {req_addr[31:2+OFF_W], next_beat, 2'b00};
                        if (last_beat) begin
                            valid[r_idx] <= 1'b1;
                            mem_req      <= 1'b0;
                            state        <= DONE;
                        end
                    end
                end
                WRITE: begin
                    if (mem_ready) begin
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_wdata <= '0;
                        mem_wstrb <= '0;
                        state     <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // The store merge reuses the aligned strobes and data already held on the memory port.
    always_ff @(posedge clk) begin
        if (fill_we) begin
            data[r_idx][beat] <= mem_rdata;
            if (last_beat) tags[r_idx] <= r_tag;
        end
        if (merge_we) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_wstrb[b]) data[r_idx][r_off][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
    end

endmodule
